// File: rtl/usart_rx.sv
// USART receiver: 2-flop synchronized line, mid-bit sampling,
// one-cycle valid / frame_err strobes, configurable data and stop bits.
module usart_rx #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CPB  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int BW   = $clog2(DATA_BITS);

  localparam logic [CW-1:0] C_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          S_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               r_state;
  logic                 r_sync;
  logic                 r_rx_s;
  logic                 r_prev;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit;
  logic                 r_stop;
  logic                 r_err;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;

  logic w_tick;
  logic w_err;

  assign w_tick    = (r_cnt == C_LAST);
  assign w_err     = r_err | ~r_rx_s;
  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (r_state != IDLE);

  // Idle-high reset values keep a line already low from looking like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= 1'b1;
      r_rx_s <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= rx;
      r_rx_s <= r_sync;
      r_prev <= r_rx_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_err   <= 1'b0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (r_prev && !r_rx_s) r_state <= START;
        end
        START: begin
          if (r_cnt == C_HALF) begin
            r_cnt <= '0;
            r_bit <= '0;
            r_state <= r_rx_s ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DATA: begin
          if (w_tick) begin
            r_cnt   <= '0;
            // LSB arrives first, so shifting in from the top lands it at bit 0.
            r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit == B_LAST) begin
              r_state <= STOP;
              r_stop  <= 1'b0;
              r_err   <= 1'b0;
            end else begin
              r_bit <= r_bit + BW'(1);
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        STOP: begin
          if (w_tick) begin
            r_cnt <= '0;
            r_err <= w_err;
            if (r_stop == S_LAST) begin
              r_state <= IDLE;
              if (w_err) begin
                r_ferr <= 1'b1;
              end else begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end
            end else begin
              r_stop <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
